latrsnq_stim_seq: RTL
=====================

Name: latrsnq_stim_seq

Overview:
- Stimulus/check sequencer that drives the E, D, RN and SETN pins of one latrsnq latch instance and checks its Q output.
- Each operation honours the latch's setup, hold, minimum pulse width and recovery windows, counted in CLK cycles.
- Sits in the library self-test and characterisation harness. The latch is the receiver; this block is the transmitter.

Parameters:
- SETUP_CYC, 2: minimum cycles D is stable before E falls (1..255).
- HOLD_CYC, 1: cycles D is kept stable after E falls (1..255).
- PW_CYC, 2: minimum high width of E and minimum low width of RN/SETN (1..255).
- RECOV_CYC, 2: cycles between RN/SETN release and the Q check (1..255).

Ports:
- CLK  input  1  clock; all registers update on the rising edge.
- RN  input  1  asynchronous active-low reset of this sequencer.
- START  input  1  request; sampled only in IDLE.
- MODE  input  2  operation: 0 = write D=0, 1 = write D=1, 2 = clear via RN, 3 = set via SETN.
- Q_IN  input  1  latch Q, registered once inside CHECK.
- LAT_E  output  1  drives latch E.
- LAT_D  output  1  drives latch D.
- LAT_RN  output  1  drives latch RN.
- LAT_SETN  output  1  drives latch SETN.
- BUSY  output  1  high from START acceptance until the DONE cycle.
- DONE  output  1  one-cycle pulse at operation end.
- PASS  output  1  result of the last check; valid while DONE is high, held until the next DONE.
- FAIL_CNT  output  8  saturating count of failed checks.

Behaviour:
- Reset is asynchronous, active-low, on RN; CLK is the only clock.
- Reset values: LAT_E=0, LAT_D=0, LAT_RN=1, LAT_SETN=1, BUSY=0, DONE=0, PASS=0, FAIL_CNT=0, state=IDLE.
- Reset mid-operation aborts immediately to the reset values. LAT_RN and LAT_SETN return high asynchronously.
- States: IDLE, WR_EN, WR_HOLD, ASSERT, RECOV, CHECK. An 8-bit down-counter times every state except IDLE and CHECK.
- START is accepted at edge k when START=1 in IDLE. That edge sets BUSY=1 and loads the first state's count.
- START is ignored while BUSY=1. Requests are not queued.
- Write, MODE 0/1:
  - At edge k: LAT_D=MODE[0], LAT_E=1, state WR_EN for W = max(PW_CYC, SETUP_CYC) cycles.
  - At edge k+W: LAT_E=0, state WR_HOLD for HOLD_CYC cycles; LAT_D unchanged.
  - Then CHECK, with expected value = MODE[0].
- Clear, MODE 2:
  - At edge k: LAT_RN=0, LAT_E=0, state ASSERT for PW_CYC cycles.
  - Then LAT_RN=1, state RECOV for RECOV_CYC cycles.
  - Then CHECK, with expected value = 0.
- Set, MODE 3: same as clear, using LAT_SETN instead of LAT_RN. Expected value = 1.
- LAT_RN and LAT_SETN are never low at the same time. LAT_E is never high while either is low.
- LAT_D holds its last written value after an operation. It changes only in WR_EN entry or on reset.
- CHECK lasts one cycle and samples Q_IN at its ending edge. That same edge:
  - sets DONE=1 for one cycle, BUSY=0, state IDLE;
  - sets PASS = (Q_IN == expected);
  - increments FAIL_CNT on mismatch, saturating at 255.
- Latency from acceptance edge to DONE edge:
  - write: W + HOLD_CYC + 1;
  - clear/set: PW_CYC + RECOV_CYC + 1.
- START may be high in the DONE cycle. It is accepted at the next edge, because the state is already IDLE.
- MODE is captured at acceptance. Later MODE changes have no effect on the running operation.
- Q_IN equal to X or Z counts as a mismatch (PASS=0).

Test Plan:
- Reset then idle: RN low then high, no START -> LAT_E=0, LAT_D=0, LAT_RN=1, LAT_SETN=1, BUSY=0, FAIL_CNT=0 on every cycle.
- Write 1 with defaults:
  - stimulus: START with MODE=1 at edge k; Q_IN follows LAT_D.
  - response: LAT_E high for edges k..k+1 and low from k+2; LAT_D=1 from k; DONE=1 at k+4 only; PASS=1; FAIL_CNT=0.
- Clear with defaults:
  - stimulus: MODE=2 at edge k; Q_IN=0 after LAT_RN falls.
  - response: LAT_RN low for exactly 2 cycles (k..k+1); DONE at k+5; PASS=1.
- Set with forced failure:
  - stimulus: MODE=3 while Q_IN is tied to 0.
  - response: LAT_SETN low for 2 cycles; DONE at k+5; PASS=0; FAIL_CNT=1. After 300 such runs, FAIL_CNT=255.
- Busy and mid-operation reset:
  - stimulus: START pulsed every cycle during a write; RN pulsed low while in WR_EN.
  - response: only the first START is accepted. After the reset pulse, LAT_E=0 immediately, BUSY=0, and no DONE is produced.
- Back-to-back with SETUP_CYC=5, PW_CYC=2, HOLD_CYC=3:
  - stimulus: START held high.
  - response: LAT_E high for 5 cycles; DONE spacing is 10 cycles (9-cycle latency plus the acceptance cycle after DONE).

Source files
------------

// File: rtl/latrsnq_stim_seq_if.sv
// Control and latch-pin bundle for the latrsnq stimulus sequencer.
// slave: the sequencer itself; master: the harness that requests operations
// and supplies the latch Q.
interface latrsnq_stim_seq_if;
  logic       START;
  logic [1:0] MODE;
  logic       Q_IN;
  logic       LAT_E;
  logic       LAT_D;
  logic       LAT_RN;
  logic       LAT_SETN;
  logic       BUSY;
  logic       DONE;
  logic       PASS;
  logic [7:0] FAIL_CNT;

  modport master (
    output START, MODE, Q_IN,
    input  LAT_E, LAT_D, LAT_RN, LAT_SETN, BUSY, DONE, PASS, FAIL_CNT
  );

  modport slave (
    input  START, MODE, Q_IN,
    output LAT_E, LAT_D, LAT_RN, LAT_SETN, BUSY, DONE, PASS, FAIL_CNT
  );
endinterface

// File: rtl/latrsnq_stim_seq.sv
// Stimulus/check sequencer for one latrsnq latch: performs a timed write,
// clear or set, then samples Q and records pass/fail.
module latrsnq_stim_seq #(
  parameter int unsigned SETUP_CYC = 2,
  parameter int unsigned HOLD_CYC  = 1,
  parameter int unsigned PW_CYC    = 2,
  parameter int unsigned RECOV_CYC = 2
) (
  input logic              CLK,
  input logic              RN,
  latrsnq_stim_seq_if.slave bus
);

  // E must satisfy both its own pulse width and the D setup before its fall.
  localparam int unsigned W_CYC = (PW_CYC > SETUP_CYC) ? PW_CYC : SETUP_CYC;

  // Counters run from N-1 down to 0, so a state loaded with N lasts N cycles.
  localparam logic [7:0] LD_W     = 8'(W_CYC - 1);
  localparam logic [7:0] LD_HOLD  = 8'(HOLD_CYC - 1);
  localparam logic [7:0] LD_PW    = 8'(PW_CYC - 1);
  localparam logic [7:0] LD_RECOV = 8'(RECOV_CYC - 1);

  typedef enum logic [2:0] {
    IDLE,
    WR_EN,
    WR_HOLD,
    ASSERT,
    RECOV,
    CHECK
  } state_t;

  state_t     r_state, w_state;
  logic [7:0] r_cnt, w_cnt;
  logic       r_exp, w_exp;
  logic       r_e, w_e;
  logic       r_d, w_d;
  logic       r_rn, w_rn;
  logic       r_setn, w_setn;
  logic       r_busy, w_busy;
  logic       r_done, w_done;
  logic       r_pass, w_pass;
  logic [7:0] r_fail_cnt, w_fail_cnt;

  // State and output registers; reset forces latch pins to their safe levels.
  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_exp      <= 1'b0;
      r_e        <= 1'b0;
      r_d        <= 1'b0;
      r_rn       <= 1'b1;
      r_setn     <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_pass     <= 1'b0;
      r_fail_cnt <= '0;
    end else begin
      r_state    <= w_state;
      r_cnt      <= w_cnt;
      r_exp      <= w_exp;
      r_e        <= w_e;
      r_d        <= w_d;
      r_rn       <= w_rn;
      r_setn     <= w_setn;
      r_busy     <= w_busy;
      r_done     <= w_done;
      r_pass     <= w_pass;
      r_fail_cnt <= w_fail_cnt;
    end
  end

  // Next-state, countdown and pin sequencing for each operation.
  always_comb begin
    w_state    = r_state;
    w_cnt      = r_cnt;
    w_exp      = r_exp;
    w_e        = r_e;
    w_d        = r_d;
    w_rn       = r_rn;
    w_setn     = r_setn;
    w_busy     = r_busy;
    w_done     = 1'b0;
    w_pass     = r_pass;
    w_fail_cnt = r_fail_cnt;

    case (r_state)
      IDLE: begin
        if (bus.START) begin
          w_busy = 1'b1;
          // MODE[0] is the expected Q for every mode: write data, 0 for clear, 1 for set.
          w_exp  = bus.MODE[0];
          if (!bus.MODE[1]) begin
            w_state = WR_EN;
            w_cnt   = LD_W;
            w_d     = bus.MODE[0];
            w_e     = 1'b1;
          end else begin
            w_state = ASSERT;
            w_cnt   = LD_PW;
            w_e     = 1'b0;
            if (bus.MODE[0]) begin
              w_setn = 1'b0;
            end else begin
              w_rn = 1'b0;
            end
          end
        end
      end

      WR_EN: begin
        if (r_cnt == '0) begin
          w_e     = 1'b0;
          w_state = WR_HOLD;
          w_cnt   = LD_HOLD;
        end else begin
          w_cnt = r_cnt - 8'd1;
        end
      end

      WR_HOLD: begin
        if (r_cnt == '0) begin
          w_state = CHECK;
        end else begin
          w_cnt = r_cnt - 8'd1;
        end
      end

      ASSERT: begin
        if (r_cnt == '0) begin
          w_rn    = 1'b1;
          w_setn  = 1'b1;
          w_state = RECOV;
          w_cnt   = LD_RECOV;
        end else begin
          w_cnt = r_cnt - 8'd1;
        end
      end

      RECOV: begin
        if (r_cnt == '0) begin
          w_state = CHECK;
        end else begin
          w_cnt = r_cnt - 8'd1;
        end
      end

      CHECK: begin
        w_state = IDLE;
        w_busy  = 1'b0;
        w_done  = 1'b1;
        // An unknown Q takes the else branch, so it is scored as a mismatch.
        if (bus.Q_IN == r_exp) begin
          w_pass = 1'b1;
        end else begin
          w_pass = 1'b0;
          if (r_fail_cnt != '1) begin
            w_fail_cnt = r_fail_cnt + 8'd1;
          end
        end
      end

      default: begin
        w_state = IDLE;
      end
    endcase
  end

  assign bus.LAT_E    = r_e;
  assign bus.LAT_D    = r_d;
  assign bus.LAT_RN   = r_rn;
  assign bus.LAT_SETN = r_setn;
  assign bus.BUSY     = r_busy;
  assign bus.DONE     = r_done;
  assign bus.PASS     = r_pass;
  assign bus.FAIL_CNT = r_fail_cnt;

endmodule
